// File: rtl/sprite_mover.sv
// Sprite engine: draws a W x H block at a fixed column and a clamped, movable row,
// erasing and redrawing it once every FRAME_DIV frame ticks.
module sprite_mover #(
    parameter int           W         = 4,
    parameter int           H         = 4,
    parameter int           X_POS     = 10,
    parameter int           Y_INIT    = 60,
    parameter int           Y_MIN     = 0,
    parameter int           Y_MAX     = 114,
    parameter int           STEP      = 1,
    parameter int           FRAME_DIV = 15,
    parameter logic [2:0]   FG        = 3'b111,
    parameter logic [2:0]   BG        = 3'b000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       go,
    input  logic       frame_tick,
    input  logic       up,
    input  logic       down,
    output logic [8:0] x_out,
    output logic [7:0] y_out,
    output logic [2:0] color_out,
    output logic       plot,
    output logic       busy,
    output logic [7:0] y_pos
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAW,
        S_WAIT,
        S_ERASE,
        S_MOVE
    } state_t;

    localparam logic [3:0] XC_LAST = 4'(W - 1);
    localparam logic [3:0] YC_LAST = 4'(H - 1);
    localparam logic [7:0] FC_LAST = 8'(FRAME_DIV - 1);
    localparam logic [8:0] Y_MIN9  = 9'(Y_MIN);
    localparam logic [8:0] Y_MAX9  = 9'(Y_MAX);
    localparam logic [8:0] STEP9   = 9'(STEP);
    localparam logic [8:0] X_POS9  = 9'(X_POS);

    state_t     state_q, state_d;
    logic [7:0] y_q, y_d;
    logic [3:0] xc_q, xc_d;
    logic [3:0] yc_q, yc_d;
    logic [7:0] fc_q, fc_d;

    logic       last_pixel;
    logic       last_tick;
    logic [8:0] y_ext;
    logic [8:0] y_up;
    logic [8:0] y_dn;

    assign last_pixel = (xc_q == XC_LAST) && (yc_q == YC_LAST);
    assign last_tick  = frame_tick && (fc_q == FC_LAST);

    // Clamps are evaluated one bit wider so y-STEP and y+STEP never wrap.
    assign y_ext = {1'b0, y_q};
    assign y_up  = (y_ext < Y_MIN9 + STEP9) ? Y_MIN9 : y_ext - STEP9;
    assign y_dn  = (y_ext + STEP9 > Y_MAX9) ? Y_MAX9 : y_ext + STEP9;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            y_q     <= 8'(Y_INIT);
            xc_q    <= 4'd0;
            yc_q    <= 4'd0;
            fc_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            xc_q    <= xc_d;
            yc_q    <= yc_d;
            fc_q    <= fc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go)         state_d = S_DRAW;
            S_DRAW:  if (last_pixel) state_d = S_WAIT;
            S_WAIT:  if (last_tick)  state_d = S_ERASE;
            S_ERASE: if (last_pixel) state_d = S_MOVE;
            S_MOVE:                  state_d = S_DRAW;
            default:                 state_d = S_IDLE;
        endcase
    end

    // Pixel counters sweep row-major and rest at zero outside DRAW/ERASE.
    always_comb begin
        y_d  = y_q;
        xc_d = 4'd0;
        yc_d = 4'd0;
        fc_d = fc_q;
        case (state_q)
            S_DRAW, S_ERASE: begin
                if (last_pixel) begin
                    if (state_q == S_DRAW) fc_d = 8'd0;
                end else if (xc_q == XC_LAST) begin
                    yc_d = yc_q + 4'd1;
                end else begin
                    xc_d = xc_q + 4'd1;
                    yc_d = yc_q;
                end
            end
            S_WAIT: begin
                if (last_tick)       fc_d = 8'd0;
                else if (frame_tick) fc_d = fc_q + 8'd1;
            end
            S_MOVE: begin
                if (up && !down)      y_d = y_up[7:0];
                else if (down && !up) y_d = y_dn[7:0];
            end
            default: fc_d = 8'd0;
        endcase
    end

    always_comb begin
        plot      = (state_q == S_DRAW) || (state_q == S_ERASE);
        busy      = (state_q != S_IDLE);
        color_out = (state_q == S_DRAW) ? FG : BG;
        x_out     = X_POS9 + {5'd0, xc_q};
        y_out     = y_q + {4'd0, yc_q};
        y_pos     = y_q;
    end

endmodule

// File: tb/tb_sprite_mover.sv
// Self-checking bench for sprite_mover: a pixel-index reference model checked every
// cycle, plus literal expectations for the first frame, clamping and mid-draw reset.
module tb_sprite_mover;

    localparam int         W         = 4;
    localparam int         H         = 3;
    localparam int         X_POS     = 10;
    localparam int         Y_INIT    = 62;
    localparam int         Y_MIN     = 0;
    localparam int         Y_MAX     = 114;
    localparam int         STEP      = 4;
    localparam int         FRAME_DIV = 2;
    localparam logic [2:0] FG        = 3'b101;
    localparam logic [2:0] BG        = 3'b010;

    localparam int P_IDLE = 0, P_DRAW = 1, P_WAIT = 2, P_ERASE = 3, P_MOVE = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       go;
    logic       frame_tick;
    logic       up;
    logic       down;
    logic [8:0] x_out;
    logic [7:0] y_out;
    logic [2:0] color_out;
    logic       plot;
    logic       busy;
    logic [7:0] y_pos;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    int m_phase;
    int m_k;
    int m_y;
    int m_ticks;

    int lit_x[12] = '{10, 11, 12, 13, 10, 11, 12, 13, 10, 11, 12, 13};
    int lit_y[12] = '{62, 62, 62, 62, 63, 63, 63, 63, 64, 64, 64, 64};

    sprite_mover #(
        .W(W), .H(H), .X_POS(X_POS), .Y_INIT(Y_INIT), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
        .STEP(STEP), .FRAME_DIV(FRAME_DIV), .FG(FG), .BG(BG)
    ) dut (
        .clk(clk), .reset_n(reset_n), .go(go), .frame_tick(frame_tick),
        .up(up), .down(down), .x_out(x_out), .y_out(y_out), .color_out(color_out),
        .plot(plot), .busy(busy), .y_pos(y_pos)
    );

    always #5 clk = ~clk;

    // Reference model: a pixel index k walks 0..W*H-1; position comes from k div/mod W.
    always @(posedge clk) begin
        if (!reset_n) begin
            m_phase = P_IDLE;
            m_y     = Y_INIT;
            m_k     = 0;
            m_ticks = 0;
        end else begin
            case (m_phase)
                P_IDLE: if (go) begin m_phase = P_DRAW; m_k = 0; end
                P_DRAW: begin
                    if (m_k == W * H - 1) begin m_phase = P_WAIT; m_ticks = 0; end
                    else m_k++;
                end
                P_WAIT: if (frame_tick) begin
                    m_ticks++;
                    if (m_ticks == FRAME_DIV) begin m_phase = P_ERASE; m_k = 0; end
                end
                P_ERASE: begin
                    if (m_k == W * H - 1) m_phase = P_MOVE;
                    else m_k++;
                end
                default: begin
                    if (up && !down)      m_y = (m_y - STEP < Y_MIN) ? Y_MIN : m_y - STEP;
                    else if (down && !up) m_y = (m_y + STEP > Y_MAX) ? Y_MAX : m_y + STEP;
                    m_phase = P_DRAW;
                    m_k     = 0;
                end
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            logic        e_plot;
            logic [31:0] e_vec;
            logic [31:0] a_vec;
            e_plot = (m_phase == P_DRAW) || (m_phase == P_ERASE);
            e_vec  = {2'b00, e_plot, 1'(m_phase != P_IDLE),
                      (m_phase == P_DRAW) ? FG : BG,
                      9'(X_POS + (e_plot ? m_k % W : 0)),
                      8'(m_y + (e_plot ? m_k / W : 0)),
                      8'(m_y)};
            a_vec  = {2'b00, plot, busy, color_out, x_out, y_out, y_pos};
            checkOutput("model", a_vec, e_vec);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic g, input logic t, input logic u, input logic d);
        go         = g;
        frame_tick = t;
        up         = u;
        down       = d;
    endtask

    task automatic pulseTick();
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
    endtask

    // Full update with one extra tick thrown in during ERASE, which must be lost.
    task automatic doUpdate();
        pulseTick();
        step(3);
        pulseTick();
        step(5);
        pulseTick();
        step(20);
    endtask

    initial begin
        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        check_en = 1'b1;
        step(2);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_state", {2'b00, plot, busy, color_out, x_out, y_out, y_pos},
                    {2'b00, 1'b0, 1'b0, 3'b010, 9'd10, 8'd62, 8'd62});
        step(2);

        go = 1'b1;
        step(1);
        go = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checkOutput($sformatf("first_pixel_%0d", i),
                        {12'd0, plot, color_out, x_out, y_out},
                        {12'd0, 1'b1, 3'b101, 9'(lit_x[i]), 8'(lit_y[i])});
        end
        @(negedge clk);
        checkOutput("after_draw", {30'd0, plot, busy}, {30'd0, 1'b0, 1'b1});
        step(3);

        up = 1'b1;
        pulseTick();
        step(4);
        @(negedge clk);
        checkOutput("no_plot_first_tick", {31'd0, plot}, 32'd0);
        step(1);
        pulseTick();
        @(negedge clk);
        checkOutput("erase_first", {20'd0, plot, color_out, y_out}, {20'd0, 1'b1, 3'b010, 8'd62});
        step(13);
        @(negedge clk);
        checkOutput("redraw_first", {11'd0, plot, color_out, x_out, y_out},
                    {11'd0, 1'b1, 3'b101, 9'd10, 8'd58});
        step(13);
        checkOutput("y_after_up", {24'd0, y_pos}, 32'd58);

        for (int i = 0; i < 14; i++) doUpdate();
        checkOutput("y_before_clamp", {24'd0, y_pos}, 32'd2);
        doUpdate();
        checkOutput("y_clamp_min", {24'd0, y_pos}, 32'd0);
        doUpdate();
        checkOutput("y_hold_min", {24'd0, y_pos}, 32'd0);

        up   = 1'b0;
        down = 1'b1;
        for (int i = 0; i < 28; i++) doUpdate();
        checkOutput("y_before_max", {24'd0, y_pos}, 32'd112);
        doUpdate();
        checkOutput("y_clamp_max", {24'd0, y_pos}, 32'd114);
        doUpdate();
        checkOutput("y_hold_max", {24'd0, y_pos}, 32'd114);

        up = 1'b1;
        doUpdate();
        checkOutput("y_both_pressed", {24'd0, y_pos}, 32'd114);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        pulseTick();
        step(2);
        pulseTick();
        step(17);
        @(negedge clk);
        checkOutput("draw5_plot", {31'd0, plot}, 32'd1);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("mid_reset", {22'd0, plot, busy, y_pos}, {22'd0, 1'b0, 1'b0, 8'd62});
        step(1);
        pulseTick();
        step(2);
        pulseTick();
        step(3);
        checkOutput("stay_idle", {31'd0, busy}, 32'd0);
        go = 1'b1;
        step(1);
        go = 1'b0;
        @(negedge clk);
        checkOutput("restart_pixel", {14'd0, plot, x_out, y_out}, {14'd0, 1'b1, 9'd10, 8'd62});
        step(15);

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_mover.md
# sprite_mover

Parametrised sprite engine for the VGA pixel-writer path. It paints a W×H rectangular sprite at a fixed column and a vertically movable row. On every FRAME_DIV-th frame tick it erases the old image, applies one up/down step with clamping, and redraws. It sits between the keyboard/KEY input logic and the VGA adapter's (x, y, colour, plot) port.

## Interface
Parameters:
- W, 4: sprite width in pixels, 1..16
- H, 4: sprite height in pixels, 1..16
- X_POS, 10: left column of the sprite, 9-bit; X_POS+W-1 ≤ 319
- Y_INIT, 60: top row after reset, 8-bit
- Y_MIN, 0: smallest allowed top row
- Y_MAX, 114: largest allowed top row; Y_MAX+H-1 ≤ 119
- STEP, 1: rows moved per update, 1..15
- FRAME_DIV, 15: frame ticks per update, 1..255
- FG, 3'b111: sprite colour
- BG, 3'b000: erase colour

Ports:
- clk, in, 1: system clock (CLOCK_50 domain)
- reset_n, in, 1: synchronous, active-low reset
- go, in, 1: start; sampled only in IDLE
- frame_tick, in, 1: one-cycle pulse per video frame
- up, in, 1: move request toward row 0 (level)
- down, in, 1: move request toward larger rows (level)
- x_out, out, 9: pixel column
- y_out, out, 8: pixel row
- color_out, out, 3: pixel colour
- plot, out, 1: write enable; the pixel is valid when plot=1
- busy, out, 1: high in every state except IDLE
- y_pos, out, 8: current committed top row

## Operation
- Internal registers:
  - state
  - y (8b): committed top row
  - xc (4b), yc (4b): pixel counters
  - fc (8b): frame counter
- States: IDLE → DRAW → WAIT → ERASE → MOVE → DRAW → …
- IDLE:
  - plot=0.
  - go=1 at an edge → DRAW, with xc=yc=0.
- DRAW:
  - plot=1, color_out=FG.
  - Pixel order is row-major: xc increments every cycle; at xc=W-1, xc wraps to 0 and yc increments.
  - The cycle with xc=W-1 and yc=H-1 is the last pixel. On that edge: → WAIT, fc=0.
- WAIT:
  - plot=0.
  - Each frame_tick increments fc.
  - A tick arriving when fc=FRAME_DIV-1 → ERASE, with xc=yc=0.
- ERASE:
  - Identical sweep to DRAW at the same y, with color_out=BG.
  - Last pixel → MOVE.
- MOVE: one cycle, plot=0. Update y:
  - up=1, down=0: y ← (y < Y_MIN+STEP) ? Y_MIN : y-STEP
  - down=1, up=0: y ← (y > Y_MAX-STEP) ? Y_MAX : y+STEP
  - Both or neither: y unchanged, but still → DRAW (redraw is unconditional).
- Clamp arithmetic: compute in 9 bits so that no wrap-around occurs; y is never outside [Y_MIN, Y_MAX].
- Outputs:
  - x_out = X_POS + xc.
  - y_out = y + yc.
  - In non-plot states, xc=yc=0.
  - All outputs are combinational from registers only (no input-to-output paths).
- Ignored inputs:
  - frame_tick is ignored outside WAIT; ticks are not queued.
  - go is ignored outside IDLE.
  - up/down are sampled only in MOVE.
- busy = (state ≠ IDLE).
- y_pos = y.

## Timing
- Reset values (state is IDLE):
  - y=Y_INIT, xc=yc=fc=0
  - plot=0, busy=0, color_out=BG
  - x_out=X_POS, y_out=Y_INIT, y_pos=Y_INIT
- Reset mid-operation: any state → IDLE at the next edge. plot is low from the next cycle, and y returns to Y_INIT.
- Latency:
  - go high at edge k → first DRAW pixel valid in cycle k+1.
  - DRAW lasts exactly W·H cycles.
- Update cost:
  - From the qualifying tick edge: W·H ERASE cycles + 1 MOVE cycle + W·H DRAW cycles = 2·W·H+1.
  - At defaults this is 33 cycles, far shorter than one frame.
- Move rate: one update per FRAME_DIV frame ticks. The tick count restarts after each DRAW; ticks during ERASE, MOVE and DRAW are lost.
- The new y is visible on y_out in the first DRAW cycle after MOVE.

## Test plan
- Reset then go (defaults):
  - plot is high for 16 cycles.
  - Pixels appear in order (10,60),(11,60),(12,60),(13,60),(10,61)…(13,63), all with colour 7.
  - Then plot=0 and busy=1.
- FRAME_DIV=2, up held:
  - No plot after the first tick.
  - After the second tick: 16 pixels with colour 0 at rows 60-63, then one idle cycle, then 16 pixels with colour 7 at rows 59-62; y_pos=59.
- Clamp, STEP=4, Y_INIT=2, up held: the next update gives y_pos=0 (not 254). A further update keeps y_pos=0 and still redraws at rows 0-3.
- Clamp, Y_INIT=113, STEP=4, down held: y_pos=114 and stays 114.
- up=down=1 during MOVE: y_pos unchanged; the erase and the redraw both occur at the same rows.
- reset_n=0 in the 5th DRAW cycle: plot=0 from the next cycle, busy=0, y_pos=60, and go is required to restart.
